// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pkg
// Purpose  : Shared state encoding and default sizing for the serial
//            seven-segment display controller.
// Revision : 1.0
// ============================================================================
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } sseg_state_e;

  localparam int SSEG_DATA_W  = 64;
  localparam int SSEG_CLK_DIV = 2;

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : sseg_phase_cnt
// Purpose  : Counts 0..CLK_DIV-1 and flags the last cycle of each half period.
// Revision : 1.0
// ============================================================================
module sseg_phase_cnt #(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = $clog2(CLK_DIV) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == c_TERM)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_TERM);

endmodule : sseg_phase_cnt
`default_nettype wire

// File: rtl/sseg_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_serial_ctrl
// Purpose  : Shifts a captured segment map into the daisy-chained display
//            shift registers and latches it, with one queued update.
// Revision : 1.0
// ============================================================================
module sseg_serial_ctrl
  import sseg_pkg::*;
#(
  parameter int DATA_W    = SSEG_DATA_W,
  parameter int CLK_DIV   = SSEG_CLK_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] seg_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              sdata,
  output logic              slatch,
  output logic              sclr_n
);

  localparam int                 c_BIT_W    = $clog2(DATA_W);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

  sseg_state_e        r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_pend_buf;
  logic               r_pending;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_sclk;
  logic               r_sdata;
  logic               r_slatch;
  logic               r_sclr_n;

  logic               w_restart;
  logic               w_tick;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic [DATA_W-1:0]  w_reload;

  function automatic logic f_first_bit(input logic [DATA_W-1:0] d);
    return MSB_FIRST ? d[DATA_W-1] : d[0];
  endfunction

  // Phase counter sits at zero outside a frame so each bit starts aligned.
  assign w_restart   = (r_state == IDLE) || (r_state == DONE);
  assign w_shift_nxt = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0}
                                 : {1'b0, r_shift[DATA_W-1:1]};
  // A start in the DONE cycle is newer than anything already queued.
  assign w_reload    = start ? seg_data : r_pend_buf;

  sseg_phase_cnt #(
    .CLK_DIV   (CLK_DIV)
  ) u_phase_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_pend_buf <= '0;
      r_pending  <= 1'b0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_sdata    <= 1'b0;
      r_slatch   <= 1'b0;
      r_sclr_n   <= 1'b0;
    end else begin
      r_sclr_n <= 1'b1;
      r_done   <= 1'b0;

      if ((r_state != IDLE) && start) begin
        r_pending  <= 1'b1;
        r_pend_buf <= seg_data;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift   <= seg_data;
            r_sdata   <= f_first_bit(seg_data);
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (w_tick) begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else if (r_bit_cnt == c_LAST_BIT) begin
              r_sclk   <= 1'b0;
              r_slatch <= 1'b1;
              r_state  <= LATCH;
            end else begin
              // Data moves only on the sclk fall, centred on the next rise.
              r_sclk    <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= w_shift_nxt;
              r_sdata   <= f_first_bit(w_shift_nxt);
            end
          end
        end

        LATCH: begin
          if (w_tick) begin
            r_slatch <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end

        DONE: begin
          if (r_pending || start) begin
            r_shift   <= w_reload;
            r_sdata   <= f_first_bit(w_reload);
            r_pending <= 1'b0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_state   <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign sclk   = r_sclk;
  assign sdata  = r_sdata;
  assign slatch = r_slatch;
  assign sclr_n = r_sclr_n;

endmodule : sseg_serial_ctrl
`default_nettype wire

// File: tb/tb_sseg_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_serial_ctrl
// Purpose  : Self-checking bench for sseg_serial_ctrl (default and LSB-first).
// Revision : 1.0
// ============================================================================
module tb_sseg_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic [63:0] seg_data;
  logic        start;
  logic        sel;
  logic        start_a, start_b;

  logic a_busy, a_done, a_sclk, a_sdata, a_slatch, a_sclr_n;
  logic b_busy, b_done, b_sclk, b_sdata, b_slatch, b_sclr_n;
  logic o_busy, o_done, o_sclk, o_sdata, o_slatch, o_sclr_n;

  int checks = 0;
  int errors = 0;

  bit rise_bits[$];
  int rise_j[$];
  int done_q[$];
  int slatch_cnt;
  int slatch_first;
  int busy_low_j;
  bit toggle_en;
  int s_j[$];
  logic [63:0] s_d[$];

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_done   = sel ? b_done   : a_done;
  assign o_sclk   = sel ? b_sclk   : a_sclk;
  assign o_sdata  = sel ? b_sdata  : a_sdata;
  assign o_slatch = sel ? b_slatch : a_slatch;
  assign o_sclr_n = sel ? b_sclr_n : a_sclr_n;

  sseg_serial_ctrl u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_data (seg_data),
    .start    (start_a),
    .busy     (a_busy),
    .done     (a_done),
    .sclk     (a_sclk),
    .sdata    (a_sdata),
    .slatch   (a_slatch),
    .sclr_n   (a_sclr_n)
  );

  sseg_serial_ctrl #(
    .DATA_W    (64),
    .CLK_DIV   (1),
    .MSB_FIRST (1'b0)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_data (seg_data),
    .start    (start_b),
    .busy     (b_busy),
    .done     (b_done),
    .sclk     (b_sclk),
    .sdata    (b_sdata),
    .slatch   (b_slatch),
    .sclr_n   (b_sclr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    rise_bits.delete();
    rise_j.delete();
    done_q.delete();
    slatch_cnt   = 0;
    slatch_first = -1;
    busy_low_j   = -1;
  endtask

  task automatic kick(input logic [63:0] d);
    @(negedge clk);
    seg_data = d;
    start    = 1'b1;
  endtask

  // j counts clk edges after the start-sampling edge; j=0 is that edge.
  task automatic observe(input int n);
    logic prev;
    prev = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (o_sclk && !prev) begin
        rise_bits.push_back(o_sdata);
        rise_j.push_back(j);
      end
      prev = o_sclk;
      if (o_done) done_q.push_back(j);
      if (o_slatch) begin
        if (slatch_first < 0) slatch_first = j;
        slatch_cnt++;
      end
      if (!o_busy && busy_low_j < 0) busy_low_j = j;
      start = 1'b0;
      if (toggle_en) seg_data = ~seg_data;
      for (int i = 0; i < s_j.size(); i++) begin
        if (s_j[i] == j) begin
          start    = 1'b1;
          seg_data = s_d[i];
        end
      end
    end
  endtask

  task automatic chk_bits(input string name, input int off, input logic [63:0] d, input bit msb);
    logic [63:0] act;
    act = '0;
    for (int k = 0; k < 64; k++) begin
      if (off + k < rise_bits.size()) begin
        if (msb) act[63-k] = rise_bits[off+k];
        else     act[k]    = rise_bits[off+k];
      end
    end
    chk(name, act, d);
  endtask

  task automatic chk_spacing(input string name, input int first, input int period);
    int bad;
    bad = 0;
    for (int k = 0; k < rise_j.size() && k < 64; k++)
      if (rise_j[k] != first + period * k) bad++;
    chk(name, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [63:0] data;
    int          first_rise;
    int          done_j;
    int          busy_low;
    int          slatch_n;
    int          slatch_j;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{64'hF0E1_D2C3_B4A5_9687, 2, 258, 259, 2, 256};
    vecs[1] = '{64'h0000_0000_0000_0000, 2, 258, 259, 2, 256};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 258, 259, 2, 256};
    vecs[3] = '{64'h8000_0000_0000_0001, 2, 258, 259, 2, 256};

    rst_n     = 1'b0;
    start     = 1'b0;
    seg_data  = '0;
    sel       = 1'b0;
    toggle_en = 1'b0;

    // Reset and release
    repeat (5) @(negedge clk);
    chk("rst_sclr_n", 64'(a_sclr_n), 64'd0);
    chk("rst_busy",   64'(a_busy),   64'd0);
    chk("rst_done",   64'(a_done),   64'd0);
    chk("rst_sclk",   64'(a_sclk),   64'd0);
    chk("rst_slatch", 64'(a_slatch), 64'd0);
    chk("rst_sdata",  64'(a_sdata),  64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_sclr_n_early", 64'(a_sclr_n), 64'd0);
    @(negedge clk);
    chk("rel_sclr_n", 64'(a_sclr_n), 64'd1);
    chk("rel_busy",   64'(a_busy),   64'd0);
    chk("rel_sclk",   64'(a_sclk),   64'd0);
    chk("rel_slatch", 64'(a_slatch), 64'd0);

    // Table-driven single frames, default parameters
    for (int v = 0; v < 4; v++) begin
      clear_obs();
      kick(vecs[v].data);
      observe(270);
      chk($sformatf("v%0d_nrise", v), 64'(rise_bits.size()), 64'd64);
      chk_bits($sformatf("v%0d_bits", v), 0, vecs[v].data, 1'b1);
      chk_spacing($sformatf("v%0d_spacing", v), vecs[v].first_rise, 4);
      chk($sformatf("v%0d_ndone", v), 64'(done_q.size()), 64'd1);
      if (done_q.size() > 0)
        chk($sformatf("v%0d_done_j", v), 64'(done_q[0]), 64'(vecs[v].done_j));
      chk($sformatf("v%0d_busy_low", v), 64'(busy_low_j), 64'(vecs[v].busy_low));
      chk($sformatf("v%0d_slatch_n", v), 64'(slatch_cnt), 64'(vecs[v].slatch_n));
      chk($sformatf("v%0d_slatch_j", v), 64'(slatch_first), 64'(vecs[v].slatch_j));
    end

    // LSB-first, CLK_DIV=1
    sel = 1'b1;
    clear_obs();
    kick(64'h1);
    observe(140);
    chk("lsb_nrise", 64'(rise_bits.size()), 64'd64);
    chk_bits("lsb_bits", 0, 64'h1, 1'b0);
    if (rise_bits.size() > 0) chk("lsb_first_bit", 64'(rise_bits[0]), 64'd1);
    chk_spacing("lsb_spacing", 1, 2);
    if (done_q.size() > 0) chk("lsb_done_j", 64'(done_q[0]), 64'd129);
    else chk("lsb_done_seen", 64'd0, 64'd1);
    chk("lsb_busy_low", 64'(busy_low_j), 64'd130);
    chk("lsb_slatch_n", 64'(slatch_cnt), 64'd1);
    sel = 1'b0;

    // Queued update: B is overwritten by C, C follows A with no idle gap
    clear_obs();
    s_j.push_back(48);  s_d.push_back(64'h5555_5555_5555_5555);
    s_j.push_back(98);  s_d.push_back(64'h0F0F_0F0F_0F0F_0F0F);
    kick(64'hAAAA_AAAA_AAAA_AAAA);
    observe(530);
    s_j.delete();
    s_d.delete();
    chk("q_ndone", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2) begin
      chk("q_done0", 64'(done_q[0]), 64'd258);
      chk("q_done1", 64'(done_q[1]), 64'd517);
    end
    chk("q_busy_low", 64'(busy_low_j), 64'd518);
    chk("q_nrise", 64'(rise_bits.size()), 64'd128);
    chk_bits("q_frame_a", 0,  64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    chk_bits("q_frame_c", 64, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    chk("q_slatch_n", 64'(slatch_cnt), 64'd4);

    // seg_data toggling mid-frame must not disturb the frame in flight
    clear_obs();
    toggle_en = 1'b1;
    kick(64'h0123_4567_89AB_CDEF);
    observe(265);
    toggle_en = 1'b0;
    chk_bits("tog_bits", 0, 64'h0123_4567_89AB_CDEF, 1'b1);
    if (done_q.size() > 0) chk("tog_done_j", 64'(done_q[0]), 64'd258);
    else chk("tog_done_seen", 64'd0, 64'd1);
    chk("tog_busy_low", 64'(busy_low_j), 64'd259);

    // Reset mid-frame
    clear_obs();
    kick(64'hDEAD_BEEF_CAFE_F00D);
    observe(120);
    chk("mr_busy_pre", 64'(a_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_busy",   64'(a_busy),   64'd0);
    chk("mr_sclk",   64'(a_sclk),   64'd0);
    chk("mr_sdata",  64'(a_sdata),  64'd0);
    chk("mr_slatch", 64'(a_slatch), 64'd0);
    chk("mr_done",   64'(a_done),   64'd0);
    chk("mr_sclr_n", 64'(a_sclr_n), 64'd0);
    repeat (3) @(negedge clk);
    chk("mr_no_slatch", 64'(slatch_cnt + int'(a_slatch)), 64'd0);
    chk("mr_no_done", 64'(done_q.size()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_sclr_n_rel", 64'(a_sclr_n), 64'd1);
    clear_obs();
    kick(64'h1234_5678_9ABC_DEF0);
    observe(270);
    chk_bits("mr_after_bits", 0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    if (done_q.size() > 0) chk("mr_after_done", 64'(done_q[0]), 64'd258);
    else chk("mr_after_done_seen", 64'd0, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sseg_serial_ctrl
`default_nettype wire
